// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: FSM states, instruction
// encodings, writeback selects and instruction field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GET_A  = 3'd2,
    S_GET_B  = 3'd3,
    S_EXEC   = 3'd4,
    S_WR_IMM = 3'd5,
    S_WR_REG = 3'd6
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;

endpackage

// File: rtl/instr_decoder.sv
// Combinational split of the instruction register into fields, the two
// sign-extended immediates and a flag marking supported encodings.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [2:0]  opcode_o,
  output logic [1:0]  op_o,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [1:0]  sh_o,
  output logic [2:0]  rm_o,
  output logic [15:0] sximm8_o,
  output logic [15:0] sximm5_o,
  output logic        legal_o
);

  assign opcode_o = ir_i[OPC_LSB +: 3];
  assign op_o     = ir_i[OP_LSB +: 2];
  assign rn_o     = ir_i[RN_LSB +: 3];
  assign rd_o     = ir_i[RD_LSB +: 3];
  assign sh_o     = ir_i[SH_LSB +: 2];
  assign rm_o     = ir_i[RM_LSB +: 3];

  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};

  // Every ALU op is defined; only the two MOV forms exist under 110.
  always_comb begin
    legal_o = 1'b0;
    if (opcode_o == OPC_ALU) begin
      legal_o = 1'b1;
    end else if (opcode_o == OPC_MOV) begin
      legal_o = (op_o == OP_MOV_IMM) || (op_o == OP_MOV_REG);
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register, decoder and Moore control FSM driving the 16-bit
// datapath one instruction at a time under a start/wait handshake.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       legal;
  logic       isMovImm, isMovReg, isUnary, isCmp;

  instr_decoder u_decoder (
    .ir_i     (ir_q),
    .opcode_o (opcode),
    .op_o     (op),
    .rn_o     (rn),
    .rd_o     (rd),
    .sh_o     (sh),
    .rm_o     (rm),
    .sximm8_o (sximm8),
    .sximm5_o (sximm5),
    .legal_o  (legal)
  );

  assign isMovImm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
  assign isMovReg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
  assign isCmp    = (opcode == OPC_ALU) && (op == OP_CMP);
  // Single-operand instructions skip GET_A and only fetch Rm.
  assign isUnary  = isMovReg || ((opcode == OPC_ALU) && (op == OP_MVN));

  assign ir_d = ((state_q == S_WAIT) && load) ? in : ir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    readnum  = rn;
    writenum = rn;
    write    = 1'b0;
    vsel     = VSEL_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    ALUop    = 2'b00;
    shift    = 2'b00;

    unique case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!legal)        state_d = S_WAIT;
        else if (isMovImm) state_d = S_WR_IMM;
        else if (isUnary)  state_d = S_GET_B;
        else               state_d = S_GET_A;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        shift = sh;
        loadc = !isCmp;
        loads = 1'b1;
        // MOV reg passes B through the adder with A forced to zero.
        if (isMovReg) begin
          asel = 1'b1;
        end else begin
          ALUop = op;
        end
        state_d = isCmp ? S_WAIT : S_WR_REG;
      end
      S_WR_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_WR_REG: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized self-checking bench for cpu_controller against an
// instruction-level model that lists the expected control word per busy cycle.
module tb_cpu_controller;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic [2:0]  readnum, writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  ALUop, shift;
  logic [15:0] sximm8, sximm5;

  int checkCount;
  int errorCount;

  logic [15:0] irModel;
  logic [19:0] plan[$];
  logic [19:0] obsVec;

  cpu_controller dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .load     (load),
    .s        (s),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .ALUop    (ALUop),
    .shift    (shift),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

  assign obsVec = {w, readnum, writenum, write, vsel, loada, loadb, loadc,
                   loads, asel, bsel, ALUop, shift};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, observed, expected);
    end
  endtask

  function automatic logic [19:0] mk(input logic wv, input logic [2:0] rnum,
                                     input logic [2:0] wnum, input logic wr,
                                     input logic [1:0] vs, input logic la,
                                     input logic lb, input logic lc, input logic ls,
                                     input logic as, input logic bs,
                                     input logic [1:0] alu, input logic [1:0] sh);
    return {wv, rnum, wnum, wr, vs, la, lb, lc, ls, as, bs, alu, sh};
  endfunction

  function automatic logic [15:0] sx8(input logic [15:0] ir);
    int v;
    v = int'(ir) % 256;
    if (v > 127) v = v - 256;
    return v[15:0];
  endfunction

  function automatic logic [15:0] sx5(input logic [15:0] ir);
    int v;
    v = int'(ir) % 32;
    if (v > 15) v = v - 32;
    return v[15:0];
  endfunction

  function automatic logic [2:0] rnOf(input logic [15:0] ir);
    int v;
    v = (int'(ir) / 256) % 8;
    return v[2:0];
  endfunction

  // Expected control word for each busy cycle, derived from instruction class.
  task automatic planSteps(input logic [15:0] ir);
    int opc, opf, rn, rd, sh, rm;
    logic [19:0] base;
    opc = int'(ir) / 8192;
    opf = (int'(ir) / 2048) % 4;
    rn  = (int'(ir) / 256) % 8;
    rd  = (int'(ir) / 32) % 8;
    sh  = (int'(ir) / 8) % 4;
    rm  = int'(ir) % 8;
    plan.delete();
    base = mk(0, rn[2:0], rn[2:0], 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    plan.push_back(base);
    if (opc == 6 && opf == 2) begin
      plan.push_back(mk(0, rn[2:0], rn[2:0], 1, 2'd1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    end else if ((opc == 6 && opf == 0) || (opc == 5 && opf == 3)) begin
      plan.push_back(mk(0, rm[2:0], rn[2:0], 0, 2'd0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0));
      if (opc == 6)
        plan.push_back(mk(0, rn[2:0], rn[2:0], 0, 2'd0, 0, 0, 1, 1, 1, 0, 2'd0, sh[1:0]));
      else
        plan.push_back(mk(0, rn[2:0], rn[2:0], 0, 2'd0, 0, 0, 1, 1, 0, 0, 2'd3, sh[1:0]));
      plan.push_back(mk(0, rn[2:0], rd[2:0], 1, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    end else if (opc == 5) begin
      plan.push_back(mk(0, rn[2:0], rn[2:0], 0, 2'd0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0));
      plan.push_back(mk(0, rm[2:0], rn[2:0], 0, 2'd0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0));
      plan.push_back(mk(0, rn[2:0], rn[2:0], 0, 2'd0, 0, 0, opf != 1, 1, 0, 0,
                        opf[1:0], sh[1:0]));
      if (opf != 1)
        plan.push_back(mk(0, rn[2:0], rd[2:0], 1, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    end
  endtask

  task automatic checkIdle(input string tag);
    logic [2:0] rn;
    rn = rnOf(irModel);
    checkOutput(tag, 32'(obsVec), 32'(mk(1, rn, rn, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0)));
    checkOutput({tag, "_sx8"}, 32'(sximm8), 32'(sx8(irModel)));
    checkOutput({tag, "_sx5"}, 32'(sximm5), 32'(sx5(irModel)));
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] word, input logic st);
    load = ld;
    in   = word;
    s    = st;
  endtask

  // WAIT cycle without a start; IR may still be reloaded.
  task automatic idleCycle();
    logic ld;
    logic [15:0] word;
    checkIdle("idle");
    ld   = 1'($urandom % 2);
    word = 16'($urandom);
    applyStimulus(ld, word, 1'b0);
    if (ld) irModel = word;
    @(negedge clk);
  endtask

  // Enter at a negedge in WAIT; leave at the negedge of the following WAIT cycle.
  task automatic runInstr(input logic [15:0] ir, input logic doLoad, input int abortAt);
    int n;
    checkIdle("wait");
    applyStimulus(doLoad, ir, 1'b1);
    if (doLoad) irModel = ir;
    planSteps(irModel);
    n = plan.size();
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("busy%0d", i), 32'(obsVec), 32'(plan[i]));
      checkOutput("busy_sx8", 32'(sximm8), 32'(sx8(irModel)));
      checkOutput("busy_sx5", 32'(sximm5), 32'(sx5(irModel)));
      if (i == abortAt) begin
        applyStimulus(1'b0, 16'h0000, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        irModel = 16'h0000;
        checkIdle("abort");
        #1 rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      applyStimulus(1'b1, ($urandom % 2) ? 16'hFFFF : 16'($urandom), 1'($urandom % 2));
      @(negedge clk);
    end
  endtask

  function automatic logic [15:0] randInstr();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom % 8)
      0:       return {3'b110, 2'b10, r[10:0]};
      1:       return {3'b110, 2'b00, r[10:0]};
      2, 3, 4, 5: return {3'b101, r[12:0]};
      6:       return r;
      default: return {3'b110, r[12], 1'b1, r[10:0]};
    endcase
  endfunction

  initial begin
    checkCount = 0;
    errorCount = 0;
    irModel    = 16'h0000;
    rst_n      = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0);
    #3;
    checkIdle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    runInstr(16'hD007, 1'b1, -1);
    runInstr(16'hD1F0, 1'b1, -1);
    runInstr(16'hA148, 1'b1, -1);
    runInstr(16'hA900, 1'b1, -1);
    runInstr(16'h0000, 1'b1, -1);
    runInstr(16'hA148, 1'b1, 3);
    runInstr(16'hD007, 1'b1, -1);

    for (int k = 0; k < 200; k++) begin
      if ($urandom % 4 == 0) idleCycle();
      else runInstr(randInstr(), ($urandom % 4) != 0, -1);
    end
    checkIdle("final");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
